// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable, big-endian data memory for the MEM stage.
// Supports byte, halfword and word accesses with zero or sign extension on reads.
// A fixed number of wait states sits between accept and response.
// After reset, an init sequence clears the whole array.
// Optional macro DATA_MEM_ALIGN_CHECK_EN: flags misaligned halfword/word accesses
// instead of force-aligning them.
module data_mem_ctrl #(
    parameter int WORD_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                readEn,
    input  logic                writeEn,
    input  logic [1:0]          size,
    input  logic                signExt,
    input  logic [ADDR_LEN-1:0] address,
    input  logic [WORD_LEN-1:0] dataIn,
    output logic                ready,
    output logic                dataValid,
    output logic [WORD_LEN-1:0] dataOut,
    output logic                misaligned
);

    localparam int LB = $clog2(WORD_LEN / 8);   // lane-select bits
    localparam int IB = $clog2(DEPTH_WORDS);    // word-index bits
    localparam int AW = LB + IB;                // address bits that matter

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              state_q;
    logic [IB-1:0]       init_cnt_q;
    logic [3:0]          wcnt_q;
    logic                ready_q, dvalid_q, mis_q;
    logic [WORD_LEN-1:0] dout_q;
    logic                we_q, sext_q;
    logic [AW-1:0]       addr_q;
    logic [1:0]          size_q;
    logic [WORD_LEN-1:0] data_q;
    logic [WORD_LEN-1:0] mem_q [DEPTH_WORDS];

    logic                accept, go_resp;
    logic [AW-1:0]       sel_addr;
    logic [1:0]          sel_size;
    logic                sel_sext, sel_we;
    logic [LB-1:0]       off;
    int                  nbytes, sh;
    logic [7:0]          shamt;
    logic [IB-1:0]       widx;
    logic [WORD_LEN-1:0] imask, cur_word, rd_raw, rd_ext, wr_word;
    logic                sbit, mis_c;
    logic                unused_addr;

    // Upper address bits are ignored on purpose, so addresses wrap.
    assign unused_addr = ^address;

    assign accept = (readEn | writeEn) & ready_q;

    // On the accept cycle, decode straight from the inputs; otherwise decode from the captured request.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_addr = address[AW-1:0];
            sel_size = size;
            sel_sext = signExt;
            sel_we   = writeEn;
        end else begin
            sel_addr = addr_q;
            sel_size = size_q;
            sel_sext = sext_q;
            sel_we   = we_q;
        end
    end

    // Lane decode: force-align the offset and build the item mask and its big-endian shift.
    always_comb begin
        off    = sel_addr[LB-1:0];
        imask  = '0;
        nbytes = 1;
        imask[7:0] = '1;
        if (sel_size == 2'b01) begin
            off[0]      = 1'b0;
            nbytes      = 2;
            imask[15:0] = '1;
        end else if (sel_size[1]) begin
            off[1:0]    = 2'b00;
            nbytes      = 4;
            imask[31:0] = '1;
        end
        sh    = WORD_LEN - 8 * (int'(off) + nbytes);
        shamt = 8'(sh);
        widx  = sel_addr[LB +: IB];
    end

    // Read extraction with extension, plus the merged word for a write.
    always_comb begin
        cur_word = mem_q[widx];
        rd_raw   = (cur_word >> shamt) & imask;
        case (sel_size)
            2'b00:   sbit = rd_raw[7];
            2'b01:   sbit = rd_raw[15];
            default: sbit = rd_raw[31];
        endcase
        rd_ext  = (sel_sext & sbit) ? (rd_raw | ~imask) : rd_raw;
        wr_word = (cur_word & ~(imask << shamt)) | ((data_q & imask) << shamt);
    end

`ifdef DATA_MEM_ALIGN_CHECK_EN
    // Flag halfwords at odd addresses and words that are not 4-byte aligned.
    assign mis_c = ((sel_size == 2'b01) & sel_addr[0]) | (sel_size[1] & (|sel_addr[1:0]));
`else
    assign mis_c = 1'b0;
`endif

    // Response is entered either directly from accept (no wait states) or when the wait count ends.
    assign go_resp = ((state_q == ST_IDLE) & accept & (WAIT_STATES == 0)) |
                     ((state_q == ST_WAIT) & (wcnt_q == 4'(WAIT_STATES - 1)));

    // Control FSM with registered handshake outputs and captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wcnt_q     <= '0;
            ready_q    <= 1'b0;
            dvalid_q   <= 1'b0;
            mis_q      <= 1'b0;
            dout_q     <= '0;
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            data_q     <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == IB'(DEPTH_WORDS - 1)) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= writeEn;
                        addr_q  <= address[AW-1:0];
                        size_q  <= size;
                        sext_q  <= signExt;
                        data_q  <= dataIn;
                        ready_q <= 1'b0;
                        wcnt_q  <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
                default: begin
                    dvalid_q <= 1'b0;
                    mis_q    <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= ST_IDLE;
                end
            endcase
            if (go_resp) begin
                state_q  <= ST_RESP;
                dvalid_q <= 1'b1;
                mis_q    <= mis_c;
                if (!sel_we && !mis_c) dout_q <= rd_ext;
            end
        end
    end

    // Array writes: clear during init, read-modify-write at the end of a write response.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT)
            mem_q[init_cnt_q] <= '0;
        else if (state_q == ST_RESP && we_q && !mis_q)
            mem_q[widx] <= wr_word;
    end

    assign ready      = ready_q;
    assign dataValid  = dvalid_q;
    assign dataOut    = dout_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (WORD_LEN=32, WAIT_STATES=1, DEPTH_WORDS=16).
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, readEn, writeEn, signExt;
    logic [1:0]  size;
    logic [31:0] address, dataIn;
    wire         ready, dataValid, misaligned;
    wire  [31:0] dataOut;

    int checks = 0;
    int failures = 0;

    data_mem_ctrl #(.WORD_LEN(32), .ADDR_LEN(32), .DEPTH_WORDS(16), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .readEn(readEn), .writeEn(writeEn), .size(size),
        .signExt(signExt), .address(address), .dataIn(dataIn), .ready(ready),
        .dataValid(dataValid), .dataOut(dataOut), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    // Issue one request once ready, return the response fields and its latency.
    task automatic access(input logic we, input logic re, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] q, output logic mis, output int lat,
                          output logic rdy_after);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++; failures++;
            $display("FAIL ready_timeout got=0 want=1");
        end
        writeEn = we; readEn = re; size = sz; signExt = sx; address = a; dataIn = d;
        @(negedge clk);
        writeEn = 1'b0; readEn = 1'b0;
        lat = 1;
        while (!dataValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        q = dataOut;
        mis = misaligned;
        @(negedge clk);
        rdy_after = ready;
    endtask

    task automatic test_reset;
        logic [31:0] q; logic mis, ra; int lat, n;
        rst = 1'b1; readEn = 0; writeEn = 0; size = 0; signExt = 0; address = 0; dataIn = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (dataOut !== 32'h0 || ready !== 1'b0 || dataValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got dout=%h rdy=%b dv=%b want 0/0/0", dataOut, ready, dataValid);
        end
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 100);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL init_cycles got=%0d want=16", n);
        end
        access(0, 1, 2'b10, 0, 32'h3C, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h0) begin
            failures++;
            $display("FAIL init_read_3C got=%h want=00000000", q);
        end
    endtask

    task automatic test_word_bytes;
        logic [31:0] q; logic mis, ra; int lat;
        logic [31:0] exp_b [4];
        exp_b = '{32'h11, 32'h22, 32'h33, 32'h44};
        access(1, 0, 2'b10, 0, 32'h8, 32'h11223344, q, mis, lat, ra);
        checks++;
        if (lat != 2 || ra !== 1'b1) begin
            failures++;
            $display("FAIL wr_latency got lat=%0d rdy=%b want lat=2 rdy=1", lat, ra);
        end
        checks++;
        if (q !== 32'h0) begin
            failures++;
            $display("FAIL dout_hold_on_write got=%h want=00000000", q);
        end
        for (int i = 0; i < 4; i++) begin
            access(0, 1, 2'b00, 0, 32'h8 + i, 0, q, mis, lat, ra);
            checks++;
            if (q !== exp_b[i] || lat != 2) begin
                failures++;
                $display("FAIL rd_byte_%0d got=%h lat=%0d want=%h lat=2", i, q, lat, exp_b[i]);
            end
        end
    endtask

    task automatic test_byte_write;
        logic [31:0] q; logic mis, ra; int lat;
        access(1, 0, 2'b00, 0, 32'h9, 32'h80, q, mis, lat, ra);
        access(0, 1, 2'b10, 0, 32'h8, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h11803344) begin
            failures++;
            $display("FAIL rmw_word got=%h want=11803344", q);
        end
        access(0, 1, 2'b00, 1, 32'h9, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL byte_sext got=%h want=ffffff80", q);
        end
        access(0, 1, 2'b00, 0, 32'h9, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h00000080) begin
            failures++;
            $display("FAIL byte_zext got=%h want=00000080", q);
        end
        access(0, 1, 2'b01, 1, 32'hA, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h00003344) begin
            failures++;
            $display("FAIL half_sext_pos got=%h want=00003344", q);
        end
    endtask

    task automatic test_wrap_priority;
        logic [31:0] q; logic mis, ra; int lat;
        access(1, 1, 2'b01, 0, 32'h48, 32'h0000BEEF, q, mis, lat, ra);
        access(0, 1, 2'b10, 0, 32'h8, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'hBEEF3344) begin
            failures++;
            $display("FAIL wrap_half_write got=%h want=beef3344", q);
        end
        access(0, 1, 2'b01, 1, 32'h48, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'hFFFFBEEF) begin
            failures++;
            $display("FAIL half_sext_neg got=%h want=ffffbeef", q);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] q; logic mis, ra; int lat, n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        writeEn = 1; readEn = 0; size = 2'b10; signExt = 0; address = 32'h4; dataIn = 32'hDEADBEEF;
        @(negedge clk);
        writeEn = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        access(0, 1, 2'b10, 0, 32'h4, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h0) begin
            failures++;
            $display("FAIL reset_discard_wr got=%h want=00000000", q);
        end
        access(0, 1, 2'b10, 0, 32'h8, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h0) begin
            failures++;
            $display("FAIL reset_reclear got=%h want=00000000", q);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] q; logic mis, ra; int lat;
        access(1, 0, 2'b10, 0, 32'h0, 32'h12345678, q, mis, lat, ra);
        access(0, 1, 2'b10, 0, 32'h0, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h12345678) begin
            failures++;
            $display("FAIL word0_rd got=%h want=12345678", q);
        end
        access(1, 0, 2'b10, 0, 32'h6, 32'hCAFEF00D, q, mis, lat, ra);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        checks++;
        if (mis !== 1'b1 || lat != 2) begin
            failures++;
            $display("FAIL mis_write_flag got mis=%b lat=%0d want mis=1 lat=2", mis, lat);
        end
        access(0, 1, 2'b10, 0, 32'h6, 0, q, mis, lat, ra);
        checks++;
        if (mis !== 1'b1 || q !== 32'h12345678) begin
            failures++;
            $display("FAIL mis_read got mis=%b dout=%h want mis=1 dout=12345678", mis, q);
        end
        access(0, 1, 2'b10, 0, 32'h4, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h0 || mis !== 1'b0) begin
            failures++;
            $display("FAIL mis_no_write got=%h mis=%b want=00000000 mis=0", q, mis);
        end
`else
        checks++;
        if (mis !== 1'b0) begin
            failures++;
            $display("FAIL mis_tied_zero got=%b want=0", mis);
        end
        access(0, 1, 2'b10, 0, 32'h4, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL force_align_wr got=%h want=cafef00d", q);
        end
        access(0, 1, 2'b01, 0, 32'h5, 0, q, mis, lat, ra);
        checks++;
        if (q !== 32'h0000CAFE) begin
            failures++;
            $display("FAIL force_align_half got=%h want=0000cafe", q);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_word_bytes();
        test_byte_write();
        test_wrap_priority();
        test_reset_mid();
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
